// File: rtl/fpu_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Package  : fpu_pkg
// Brief    : Shared float field widths, integer limits, rounding-mode enum and
//            the stage records used by the float-to-integer converter.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
package fpu_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int INT_W  = 32;

    localparam logic [EXP_W-1:0] EXP_BIAS    = 8'd127;
    localparam logic [EXP_W-1:0] EXP_SPECIAL = 8'hFF;

    localparam logic [INT_W-1:0] INT_MAX = 32'h7FFF_FFFF;
    localparam logic [INT_W-1:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        RM_RNE = 2'b00,
        RM_RTZ = 2'b01,
        RM_RDN = 2'b10
    } rmode_t;

    // Stage-1 result: integer magnitude plus guard/sticky, ready for rounding.
    typedef struct packed {
        logic             sign;
        logic             nan;
        logic             huge;
        logic [INT_W-1:0] mag;
        logic             guard;
        logic             sticky;
        rmode_t           rm;
    } ftoi_dec_t;

    typedef struct packed {
        logic [INT_W-1:0] y;
        logic             ovf;
    } ftoi_res_t;

    // The reserved encoding 2'b11 behaves as round-to-nearest-even.
    function automatic rmode_t decode_rmode(input logic [1:0] code);
        return (code == 2'b11) ? RM_RNE : rmode_t'(code);
    endfunction

endpackage : fpu_pkg
`default_nettype wire

// File: rtl/fp_ftoi_round.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : fp_ftoi_round
// Brief    : Combinational round / negate / overflow stage of fp_ftoi.
//            FPU_FTOI_SATURATE_EN selects saturating overflow results.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module fp_ftoi_round
    import fpu_pkg::*;
(
    input  ftoi_dec_t dec_i,
    output ftoi_res_t res_o
);

    localparam logic [INT_W:0] TWO_POW_31 = {2'b01, {(INT_W-1){1'b0}}};

    logic             inc;
    logic [INT_W:0]   mag_r;
    logic [INT_W-1:0] signed_w;
    logic [INT_W-1:0] sat_w;
    logic             ovf_w;

    always_comb begin
        inc = 1'b0;
        case (dec_i.rm)
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = dec_i.sign && (dec_i.guard || dec_i.sticky);
            default: inc = dec_i.guard && (dec_i.sticky || dec_i.mag[0]);
        endcase
    end

    assign mag_r = {1'b0, dec_i.mag} + {{INT_W{1'b0}}, inc};

    // Only -2^31 itself survives a magnitude of exactly 2^31.
    assign ovf_w = dec_i.huge || dec_i.nan || (mag_r > TWO_POW_31) ||
                   ((mag_r == TWO_POW_31) && !dec_i.sign);

    assign signed_w = dec_i.sign ? (~mag_r[INT_W-1:0] + INT_W'(1)) : mag_r[INT_W-1:0];

`ifdef FPU_FTOI_SATURATE_EN
    assign sat_w = (dec_i.sign && !dec_i.nan) ? INT_MIN : INT_MAX;
`else
    assign sat_w = INT_MIN;
`endif

    assign res_o.y   = ovf_w ? sat_w : signed_w;
    assign res_o.ovf = ovf_w;

endmodule : fp_ftoi_round
`default_nettype wire

// File: rtl/fp_ftoi.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : fp_ftoi
// Brief    : Pipelined float32 to int32 converter with valid/ready handshake,
//            RNE/RTZ/RDN rounding and overflow flag. FPU_FTOI_SATURATE_EN
//            enables saturating overflow results.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module fp_ftoi
    import fpu_pkg::*;
#(
    parameter int NSTAGE = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INT_W-1:0]  x,
    input  logic [1:0]        rmode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INT_W-1:0]  y,
    output logic              ovf
);

    logic [EXP_W-1:0]        exp_w;
    logic [FRAC_W-1:0]       frac_w;
    logic [4:0]              shamt;
    logic [FRAC_W+INT_W-1:0] shifted;

    ftoi_dec_t dec_d;
    ftoi_dec_t dec_q;
    ftoi_res_t res_w;
    ftoi_res_t res2_q;
    logic      v1_q;
    logic      v2_q;
    logic      rdy2;
    logic      succ_rdy;

    assign exp_w  = x[30:23];
    assign frac_w = x[FRAC_W-1:0];
    assign shamt  = 5'(exp_w - EXP_BIAS);

    // Hidden one sits at bit FRAC_W; after the shift the integer part is the
    // top INT_W bits and the bits below it are guard and sticky.
    assign shifted = {{(INT_W-1){1'b0}}, 1'b1, frac_w} << shamt;

    always_comb begin
        dec_d      = '0;
        dec_d.sign = x[31];
        dec_d.rm   = decode_rmode(rmode);
        if (exp_w == EXP_SPECIAL) begin
            dec_d.huge = 1'b1;
            dec_d.nan  = |frac_w;
        end else if (exp_w >= EXP_BIAS + 8'd32) begin
            dec_d.huge = 1'b1;
        end else if (exp_w >= EXP_BIAS) begin
            dec_d.mag    = shifted[FRAC_W+INT_W-1 -: INT_W];
            dec_d.guard  = shifted[FRAC_W-1];
            dec_d.sticky = |shifted[FRAC_W-2:0];
        end else if (exp_w == EXP_BIAS - 8'd1) begin
            dec_d.guard  = 1'b1;
            dec_d.sticky = |frac_w;
        end else if (exp_w != '0) begin
            dec_d.sticky = 1'b1;
        end
        // exp == 0: zero or denormal, magnitude and round bits stay zero
    end

    assign rdy2     = !v2_q || succ_rdy;
    assign in_ready = !v1_q || rdy2;

    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            dec_q <= dec_d;
        end
    end

    fp_ftoi_round u_round (
        .dec_i (dec_q),
        .res_o (res_w)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            res2_q <= '0;
        end else begin
            if (in_ready) begin
                v1_q <= in_valid;
            end
            if (rdy2) begin
                v2_q <= v1_q;
                if (v1_q) begin
                    res2_q <= res_w;
                end
            end
        end
    end

    // Any depth other than 3 builds the two-stage pipeline.
    generate
        if (NSTAGE == 3) begin : g_out_reg
            logic      v3_q;
            ftoi_res_t res3_q;

            assign succ_rdy = !v3_q || out_ready;

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    v3_q   <= 1'b0;
                    res3_q <= '0;
                end else if (succ_rdy) begin
                    v3_q <= v2_q;
                    if (v2_q) begin
                        res3_q <= res2_q;
                    end
                end
            end

            assign out_valid = v3_q;
            assign y         = res3_q.y;
            assign ovf       = res3_q.ovf;
        end else begin : g_no_out_reg
            assign succ_rdy  = out_ready;
            assign out_valid = v2_q;
            assign y         = res2_q.y;
            assign ovf       = res2_q.ovf;
        end
    endgenerate

endmodule : fp_ftoi
`default_nettype wire

// File: doc/fp_ftoi.md
# fp_ftoi

Pipelined single-precision float to signed 32-bit integer converter with valid/ready handshake, selectable rounding (nearest-even, toward zero, toward −∞) and overflow/NaN flagging. Sits directly downstream of the FPU `floor` unit in the execute stage and implements `ftoi`-class instructions. Its result feeds the integer writeback path. With mode = floor it also consumes `floor` output bit-exactly.

## Interface
Parameters:
- `NSTAGE`, 2, pipeline depth. Legal values are 2 and 3. Value 3 adds one output register after the round stage.

Ports:
- `clk`  in  1  clock; all state updates on posedge.
- `rstn`  in  1  reset; asynchronous, active-low.
- `in_valid`  in  1  input operand valid.
- `in_ready`  out  1  block can accept an operand this cycle.
- `x`  in  32  IEEE-754 single-precision operand.
- `rmode`  in  2  rounding mode: 00 = RNE, 01 = toward zero, 10 = floor (toward −∞), 11 = reserved (treated as RNE).
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `y`  out  32  two's-complement integer result.
- `ovf`  out  1  result not representable: |value| ≥ 2^31 (except exactly −2^31), ±inf, or NaN.

## Operation
- Handshakes: input transfers when `in_valid && in_ready`; output transfers when `out_valid && out_ready`. Payload is captured together with `rmode`.
- Stage 1 (decode/shift):
  - e = exp − 127.
  - Classify: zero/denormal (exp = 0), tiny (e < 0), normal (0 ≤ e ≤ 30), big (e ≥ 31), special (exp = 255).
  - Normal: magnitude = {1,frac} aligned to integer part plus guard bit plus sticky (OR of all lower bits).
  - Denormals are treated as zero (value 0, sign kept for rounding purposes).
- Stage 2 (round/negate/flag):
  - RNE: increment if guard && (sticky || lsb).
  - Toward zero: no increment.
  - Floor: increment magnitude if sign && (guard || sticky).
  - Then negate if sign. Rounding carry into bit 31 sets `ovf` unless the result is exactly −2^31.
  - Tiny: RNE gives 0, or ±1 if e = −1 and sticky. Toward zero gives 0. Floor gives −1 (0xFFFFFFFF) for negative nonzero, else 0.
  - −0.0 yields 0 in all modes, with `ovf` = 0.
- Pipeline control:
  - Each stage holds a valid bit.
  - A stage advances when its successor is empty or advancing in the same cycle.
  - The last stage advances on `out_ready`.
  - `in_ready` = !v[0] || adv[0]. It is combinational from `out_ready` through the stage chain, not registered.
- No reordering and no dropping. Payload registers hold their value while their stage is stalled.
- Reset mid-operation: all valid bits clear immediately and in-flight results are discarded. Payload registers need not reset.

## Timing
- Latency is NSTAGE cycles from input transfer to `out_valid` with no stall.
- Throughput is one result per cycle while `out_ready` = 1.
- Reset values: `out_valid` = 0, `y` = 0, `ovf` = 0. `in_ready` = 1 one cycle after `rstn` deasserts.
- Full pipeline with `out_ready` = 0: `in_ready` = 0. The same cycle `out_ready` rises, `in_ready` = 1, so there is no bubble.
- Simultaneous input and output transfer on a full pipeline is legal and keeps occupancy constant.

## Configuration
- `FPU_FTOI_SATURATE_EN` defined: outputs are saturated.
  - Positive overflow, +inf and NaN give `y` = 0x7FFFFFFF.
  - Negative overflow and −inf give `y` = 0x80000000.
- Not defined: every `ovf` case gives `y` = 0x80000000 (integer-indefinite).
- `ovf` behaviour is identical in both builds.

## Structure
- Shared package `fpu_pkg`:
  - `rmode_t` enum (RNE, RTZ, RDN).
  - Float field widths and `EXP_BIAS` = 127.
  - Constants `INT_MAX` and `INT_MIN`.
- One sub-module, `fp_ftoi_round`: combinational stage-2 logic (round increment, negate, overflow/saturate). The top holds the stage registers and handshake.

## Test plan
- Rounding modes on ±2.5, both build configs:
  - 0x40200000 gives 2 in RNE, RTZ and RDN.
  - 0xC0200000 gives 0xFFFFFFFE in RNE and RTZ, and 0xFFFFFFFD in RDN.
  - 0x40600000 (3.5) RNE gives 4.
- Tiny values:
  - 0xBE800000 (−0.25) gives 0xFFFFFFFF in RDN and 0 in RTZ/RNE.
  - 0x3F400000 (0.75) RNE gives 1.
  - 0x80000000 gives 0.
- Boundaries:
  - 0xCF000000 gives 0x80000000 with `ovf` = 0.
  - 0x4F000000 gives `ovf` = 1 and `y` = 0x7FFFFFFF with the macro, 0x80000000 without.
  - 0x7FC00000 (NaN) gives `ovf` = 1.
- Backpressure:
  - Stream 6 operands back-to-back with `out_ready` low for 4 cycles.
  - `in_ready` must fall once NSTAGE results are held. All 6 results appear in order, none lost or duplicated.
  - Check with NSTAGE = 2 and NSTAGE = 3.
- Random regression: 10,000 `$urandom` operands in RTZ with `|x| < 2^31`. `y` equals `$rtoi` of the operand, checked against a scoreboard aligned to NSTAGE.
- Reset mid-stream: assert `rstn` = 0 with 2 results in flight.
  - `out_valid` drops asynchronously and no stale result appears after release.
  - The first new operand emerges NSTAGE cycles after its transfer.
